hazard_controller: RTL and testbench



---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_controller.sv | 119 +++++++++++
 tb/tb_hazard_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// architectural constants.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and
// data-memory wait/timeout handling, with saturating performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             Pipe_Hold,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  hz_state_t         r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_error;

  logic w_hold;
  logic w_lu;
  logic w_flush_row;
  logic w_stall_en;

  assign w_hold = dmem_req & ~dmem_ready;
  assign w_lu   = IDEX_MemRead & (IDEX_rd != REG_ZERO) &
                  ((IDEX_rd == IFID_rs1) | (IDEX_rd == IFID_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hold) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        S_MEM_WAIT: begin
          // A completing access wins over a timeout landing on the same edge.
          if (dmem_ready) begin
            r_state <= S_RUN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
              r_state     <= S_ERROR;
              r_mem_error <= 1'b1;
            end
          end
        end
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    Pipe_Hold   = 1'b0;
    w_flush_row = 1'b0;
    if (!rst_n) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (r_state == S_ERROR || w_hold) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      Pipe_Hold  = 1'b1;
    end else if (branch_taken) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      w_flush_row = 1'b1;
    end else if (w_lu) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  // ERROR freezes the PC too, but those cycles are not charged as stalls.
  assign w_stall_en = ~PC_Write & (r_state != S_ERROR);
  assign mem_error  = r_mem_error;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_stall_en),
    .o_count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_flush_row),
    .o_count (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// traffic compared every cycle against a behavioural reference model.
module tb_hazard_controller;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       rs1 = '0, rs2 = '0, rd = '0;
  logic             memread = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic             pc_w, ifid_w, ifid_f, idex_f, p_hold, mem_err;
  logic [CNT_W-1:0] stall_c, flush_c;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_wait, m_err;
  int m_wcnt, m_stall, m_flush;

  hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IFID_rs1     (rs1),
    .IFID_rs2     (rs2),
    .IDEX_rd      (rd),
    .IDEX_MemRead (memread),
    .branch_taken (br),
    .dmem_req     (req),
    .dmem_ready   (rdy),
    .PC_Write     (pc_w),
    .IFID_Write   (ifid_w),
    .IFID_Flush   (ifid_f),
    .IDEX_Flush   (idex_f),
    .Pipe_Hold    (p_hold),
    .mem_error    (mem_err),
    .stall_cycles (stall_c),
    .flush_count  (flush_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int a, input int b, input int d, input bit mr,
                       input bit bt, input bit rq, input bit rd_y);
    rs1 = 5'(a); rs2 = 5'(b); rd = 5'(d);
    memread = mr; br = bt; req = rq; rdy = rd_y;
  endtask

  task automatic idle();
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit h, l, e_pc, e_ifw, e_iff, e_idf, e_ph, frow;
    @(negedge clk);
    h = req && !rdy;
    l = memread && (rd != 0) && (rd == rs1 || rd == rs2);
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_ph = 0; frow = 0;
    if (m_err || h) begin
      e_pc = 0; e_ifw = 0; e_ph = 1;
    end else if (br) begin
      e_iff = 1; e_idf = 1; frow = 1;
    end else if (l) begin
      e_pc = 0; e_ifw = 0; e_idf = 1;
    end
    chk("PC_Write",     pc_w,    e_pc);
    chk("IFID_Write",   ifid_w,  e_ifw);
    chk("IFID_Flush",   ifid_f,  e_iff);
    chk("IDEX_Flush",   idex_f,  e_idf);
    chk("Pipe_Hold",    p_hold,  e_ph);
    chk("mem_error",    mem_err, m_err);
    chk("stall_cycles", stall_c, m_stall);
    chk("flush_count",  flush_c, m_flush);
    @(posedge clk);
    if (!m_err && !e_pc && m_stall < CNT_MAX) m_stall++;
    if (frow && m_flush < CNT_MAX) m_flush++;
    if (!m_err) begin
      if (m_wait) begin
        if (rdy) m_wait = 0;
        else begin
          m_wcnt++;
          if (m_wcnt == TIMEOUT) begin
            m_err = 1;
            m_wait = 0;
          end
        end
      end else if (h) begin
        m_wait = 1;
        m_wcnt = 0;
      end
    end
    #1;
  endtask

  // Drops rst_n immediately (possibly mid-cycle), checks reset values, releases.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst PC_Write",     pc_w,    0);
    chk("rst IFID_Write",   ifid_w,  0);
    chk("rst IFID_Flush",   ifid_f,  1);
    chk("rst IDEX_Flush",   idex_f,  1);
    chk("rst Pipe_Hold",    p_hold,  0);
    chk("rst mem_error",    mem_err, 0);
    chk("rst stall_cycles", stall_c, 0);
    chk("rst flush_count",  flush_c, 0);
    idle();
    m_wait = 0; m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Load-use: one bubble, then the bubble in EX clears the hazard
    drive(1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    drive(1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    chk("lu stall_cycles", stall_c, 1);
    drive(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    idle(); cycle();
    chk("lu x0 no stall", stall_c, 1);

    // Branch together with load-use: flush only
    do_reset();
    drive(5, 2, 5, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    idle(); cycle();
    chk("br+lu flush_count", flush_c, 1);
    chk("br+lu stall_cycles", stall_c, 0);

    // Memory wait released on third cycle, branch held throughout
    do_reset();
    drive(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0); cycle(); cycle();
    drive(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1); cycle();
    idle(); cycle();
    chk("wait stall_cycles", stall_c, 2);
    chk("wait flush_count", flush_c, 1);

    // Same-cycle req and ready: zero stall
    do_reset();
    drive(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    idle(); cycle();
    chk("req+ready no stall", stall_c, 0);

    // Timeout into sticky ERROR; late ready ignored
    do_reset();
    drive(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) cycle();
    drive(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) cycle();
    chk("timeout mem_error", mem_err, 1);
    chk("timeout stall_cycles", stall_c, 5);
    chk("timeout PC_Write", pc_w, 0);
    do_reset();
    chk("post-error PC_Write", pc_w, 1);

    // Saturation of the stall counter
    drive(3, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle();
    chk("sat stall_cycles", stall_c, CNT_MAX);

    // Async reset asserted mid-wait
    do_reset();
    drive(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0); cycle(); cycle();
    chk("midwait Pipe_Hold", p_hold, 1);
    do_reset();
    idle(); cycle();
    chk("after midwait reset PC_Write", pc_w, 1);

    // Random traffic with periodic resets
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
      cycle();
      if (i % 250 == 249) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
